pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard, stall, flush and PC-sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It sits beside the datapath stages. It detects load-use and early-branch data hazards and freezes the pipeline on Wishbone memory waits. It generates the per-stage flush mask, owns the PC register, and drives load/bubble strobes for the four pipeline registers.

## Interface
- RESET_PC, 32'h8000_0000, PC value after reset (BaseRAM base).
- clk_10M  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- id_ex_mem_read, id_ex_reg_write  in  1 each  EX-stage instruction is a load / writes a register.
- id_ex_rd  in  5  EX-stage destination register.
- ex_is_branch  in  1  EX-stage instruction is a branch/jump.
- ex_mem_mem_read  in  1  MEM-stage instruction is a load.
- ex_mem_rd  in  5  MEM-stage destination register.
- if_id_inst  in  32  ID-stage instruction word (rs1=[19:15], rs2=[24:20], opcode=[6:0]).
- branch_mispredict  in  1  EX-stage misprediction.
- branch_redirect_id  in  1  ID-stage early branch/jump taken.
- inst_mem_wait, data_mem_wait  in  1 each  Wishbone cyc&stb&!ack on the instruction / data port.
- next_pc  in  32  PC candidate from the IF stage.
- if_id_next_valid  in  1  IF produced a valid fetch this cycle.
- pc  out  32  registered program counter.
- hazard_stall, mem_stall  out  1 each  stall indications.
- flush_mask  out  5  per-stage flush, bit0=IF … bit4=WB.
- if_id_load, if_id_bubble, id_ex_load, id_ex_bubble, ex_mem_load, ex_mem_bubble, mem_wb_load, mem_wb_bubble  out  1 each  register controls. Load copies the next value. Bubble writes all-zero. Neither asserted means hold.

## Operation
- Source usage, decoded from if_id_inst opcode:
  - rs1 is used except for LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used only for R 0110011, S 0100011 and B 1100011.
  - Register x0 never creates a hazard.
- ID-branch: the opcode is B 1100011 or JALR 1100111.
- Load-use hazard: id_ex_mem_read and id_ex_rd matches a used source.
- Branch hazard applies only when ID holds an ID-branch. It is raised in either case:
  - id_ex_reg_write and id_ex_rd matches a used source; or
  - ex_mem_mem_read and ex_mem_rd matches a used source.
- mispredict_q = branch_mispredict & ex_is_branch.
- hazard_stall = (load-use | branch hazard) & !mispredict_q.
- mem_stall = inst_mem_wait | data_mem_wait.
- Flush mask:
  - flush_mask[0] = mispredict_q | (branch_redirect_id & !hazard_stall).
  - flush_mask[1] = mispredict_q.
  - flush_mask[4:2] = 0.
- PC and IF/ID, highest priority first:
  1. mem_stall: hold both.
  2. flush_mask[0]: if_id_bubble, pc <= next_pc.
  3. hazard_stall: hold both.
  4. if_id_next_valid: if_id_load, pc <= next_pc.
  5. Otherwise: if_id_bubble, pc holds.
- ID/EX, highest priority first: mem_stall hold; hazard_stall bubble; flush_mask[1] bubble; else load.
- EX/MEM and MEM/WB: mem_stall hold; else bubble if flush_mask[2] (resp. [3]), else load.
- Per register, load and bubble are mutually exclusive.

## Timing
- All outputs except pc are purely combinational from the current inputs, with zero latency.
- pc updates on the rising edge of clk_10M.
- Reset: pc = RESET_PC immediately and asynchronously. Combinational outputs follow their inputs during reset. The datapath ignores them while sys_rst is high.
- Reset is released synchronously by the upstream reset generator. The first fetch address is RESET_PC.
- mem_stall freezes every register for as long as it is asserted. A pending mispredict or redirect persists because the stage registers hold, and is applied on the first cycle without a wait.
- Mispredict together with a hazard: the mispredict wins. hazard_stall reads 0, and IF/ID and ID/EX bubble.
- Redirect together with a branch hazard: the redirect is ignored and ID stalls until its operands are forwardable.
- A load-use hazard inserts exactly one bubble. A branch depending on a load inserts two bubbles (EX, then MEM).

## Test plan
- Reset: assert sys_rst mid-run -> pc = 0x8000_0000 at once, and stays there until the first valid fetch after release.
- Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_inst=add x1,x5,x6 -> hazard_stall=1, id_ex_bubble=1, pc held. With rd=0 -> no stall.
- Branch after ALU: id_ex_reg_write=1, rd=3, if_id_inst=beq x3,x4 -> stall 1 cycle. The same with ex_mem_mem_read, ex_mem_rd=3 -> stall one more cycle.
- Redirect: branch_redirect_id=1, no hazard, next_pc=0x8000_0040 -> flush_mask=00001, if_id_bubble, next pc=0x8000_0040.
- Mispredict during load-use: branch_mispredict=ex_is_branch=1 -> flush_mask=00011, hazard_stall=0, pc <= next_pc.
- Memory wait: data_mem_wait=1 for 3 cycles with mispredict pending -> all loads/bubbles 0 and pc frozen. Flush applied on cycle 4.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard/stall/flush control bundle between the pipeline datapath and its controller.
interface pipeline_hazard_ctrl_if;
    logic        id_ex_mem_read;
    logic        id_ex_reg_write;
    logic [4:0]  id_ex_rd;
    logic        ex_is_branch;
    logic        ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;
    logic [31:0] if_id_inst;
    logic        branch_mispredict;
    logic        branch_redirect_id;
    logic        inst_mem_wait;
    logic        data_mem_wait;
    logic [31:0] next_pc;
    logic        if_id_next_valid;
    logic [31:0] pc;
    logic        hazard_stall;
    logic        mem_stall;
    logic [4:0]  flush_mask;
    logic        if_id_load;
    logic        if_id_bubble;
    logic        id_ex_load;
    logic        id_ex_bubble;
    logic        ex_mem_load;
    logic        ex_mem_bubble;
    logic        mem_wb_load;
    logic        mem_wb_bubble;

    modport master (
        output id_ex_mem_read, id_ex_reg_write, id_ex_rd, ex_is_branch, ex_mem_mem_read, ex_mem_rd,
               if_id_inst, branch_mispredict, branch_redirect_id, inst_mem_wait, data_mem_wait,
               next_pc, if_id_next_valid,
        input  pc, hazard_stall, mem_stall, flush_mask, if_id_load, if_id_bubble, id_ex_load,
               id_ex_bubble, ex_mem_load, ex_mem_bubble, mem_wb_load, mem_wb_bubble
    );

    modport slave (
        input  id_ex_mem_read, id_ex_reg_write, id_ex_rd, ex_is_branch, ex_mem_mem_read, ex_mem_rd,
               if_id_inst, branch_mispredict, branch_redirect_id, inst_mem_wait, data_mem_wait,
               next_pc, if_id_next_valid,
        output pc, hazard_stall, mem_stall, flush_mask, if_id_load, if_id_bubble, id_ex_load,
               id_ex_bubble, ex_mem_load, ex_mem_bubble, mem_wb_load, mem_wb_bubble
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / early-branch hazard detection, memory-wait freeze,
// flush mask, PC register and load/bubble strobes for the 5-stage RV32I pipeline.
module pipeline_hazard_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic                   clk_10M,
    input logic                   sys_rst,
    pipeline_hazard_ctrl_if.slave hz_io
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic        use_rs1, use_rs2, id_branch;
    logic        ex_match, mem_match, load_use, branch_haz;
    logic        mispredict, hazard_stall, mem_stall;
    logic [4:0]  flush_mask;
    logic        advance_pc;
    logic [31:0] pc_q, pc_d;
    logic        unused_inst;

    assign opcode      = hz_io.if_id_inst[6:0];
    assign rs1         = hz_io.if_id_inst[19:15];
    assign rs2         = hz_io.if_id_inst[24:20];
    assign unused_inst = ^{hz_io.if_id_inst[31:25], hz_io.if_id_inst[14:7]};

    assign use_rs1   = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign use_rs2   = opcode == OP_R || opcode == OP_S || opcode == OP_B;
    assign id_branch = opcode == OP_B || opcode == OP_JALR;

    // x0 is hardwired, so a write to it can never feed a consumer
    assign ex_match  = hz_io.id_ex_rd != 5'd0 &&
                       ((use_rs1 && hz_io.id_ex_rd == rs1) || (use_rs2 && hz_io.id_ex_rd == rs2));
    assign mem_match = hz_io.ex_mem_rd != 5'd0 &&
                       ((use_rs1 && hz_io.ex_mem_rd == rs1) || (use_rs2 && hz_io.ex_mem_rd == rs2));

    assign load_use     = hz_io.id_ex_mem_read & ex_match;
    assign branch_haz   = id_branch & ((hz_io.id_ex_reg_write & ex_match) |
                                       (hz_io.ex_mem_mem_read & mem_match));
    assign mispredict   = hz_io.branch_mispredict & hz_io.ex_is_branch;
    assign hazard_stall = (load_use | branch_haz) & !mispredict;
    assign mem_stall    = hz_io.inst_mem_wait | hz_io.data_mem_wait;
    assign flush_mask   = {3'b000, mispredict, mispredict | (hz_io.branch_redirect_id & !hazard_stall)};

    // IF/ID and PC share one priority chain: wait > flush > stall > fetch > idle
    assign advance_pc = !mem_stall & (flush_mask[0] | (!hazard_stall & hz_io.if_id_next_valid));
    assign pc_d       = advance_pc ? hz_io.next_pc : pc_q;

    always_ff @(posedge clk_10M or posedge sys_rst) begin
        if (sys_rst) pc_q <= RESET_PC;
        else         pc_q <= pc_d;
    end

    assign hz_io.pc            = pc_q;
    assign hz_io.hazard_stall  = hazard_stall;
    assign hz_io.mem_stall     = mem_stall;
    assign hz_io.flush_mask    = flush_mask;
    assign hz_io.if_id_load    = !mem_stall & !flush_mask[0] & !hazard_stall & hz_io.if_id_next_valid;
    assign hz_io.if_id_bubble  = !mem_stall & (flush_mask[0] | (!hazard_stall & !hz_io.if_id_next_valid));
    assign hz_io.id_ex_load    = !mem_stall & !hazard_stall & !flush_mask[1];
    assign hz_io.id_ex_bubble  = !mem_stall & (hazard_stall | flush_mask[1]);
    assign hz_io.ex_mem_load   = !mem_stall & !flush_mask[2];
    assign hz_io.ex_mem_bubble = !mem_stall & flush_mask[2];
    assign hz_io.mem_wb_load   = !mem_stall & !flush_mask[3];
    assign hz_io.mem_wb_bubble = !mem_stall & flush_mask[3];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed expectations, queued by the
// driver and checked by an independent negedge monitor.
module tb_pipeline_hazard_ctrl;
    logic clk_10M = 1'b0;
    logic sys_rst = 1'b0;
    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk_10M (clk_10M),
        .sys_rst (sys_rst),
        .hz_io   (hz)
    );

    always #50 clk_10M = ~clk_10M;

    // control-input bits: {mem_read, reg_write, ex_is_branch, ex_mem_mem_read, mispredict, redirect, iwait, dwait, valid}
    localparam logic [8:0] MR = 9'h100, RW = 9'h080, XB = 9'h040, EMR = 9'h020, MP = 9'h010;
    localparam logic [8:0] RD = 9'h008, IW = 9'h004, DW = 9'h002, NV = 9'h001, NONE = 9'h000;

    // outputs: {hazard_stall, mem_stall, flush_mask[4:0], ifl, ifb, idl, idb, exl, exb, mwl, mwb}
    localparam logic [14:0] O_RUN   = 15'b0_0_00000_1_0_1_0_1_0_1_0;
    localparam logic [14:0] O_IDLE  = 15'b0_0_00000_0_1_1_0_1_0_1_0;
    localparam logic [14:0] O_STALL = 15'b1_0_00000_0_0_0_1_1_0_1_0;
    localparam logic [14:0] O_REDIR = 15'b0_0_00001_0_1_1_0_1_0_1_0;
    localparam logic [14:0] O_MISP  = 15'b0_0_00011_0_1_0_1_1_0_1_0;
    localparam logic [14:0] O_WMISP = 15'b0_1_00011_0_0_0_0_0_0_0_0;
    localparam logic [14:0] O_WAIT  = 15'b0_1_00000_0_0_0_0_0_0_0_0;

    localparam logic [31:0] ADD_1_5_6  = 32'h0062_80B3;
    localparam logic [31:0] BEQ_3_4    = 32'h0041_8063;
    localparam logic [31:0] LUI_RS1F5  = 32'h0002_80B7;
    localparam logic [31:0] SW_5_2     = 32'h0051_2023;
    localparam logic [31:0] ADDI_RS2F6 = 32'h0061_0093;
    localparam logic [31:0] JALR_1_3   = 32'h0001_80E7;

    typedef struct packed {
        logic [14:0] outs;
        logic [31:0] pc;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_vec = 0;

    task automatic vec(input logic rst, input logic [8:0] c, input logic [4:0] rd_ex,
                       input logic [4:0] rd_mem, input logic [31:0] inst, input logic [31:0] npc,
                       input logic [14:0] eo, input logic [31:0] ep);
        exp_t e;
        @(posedge clk_10M);
        #1;
        sys_rst                 = rst;
        hz.id_ex_mem_read       = c[8];
        hz.id_ex_reg_write      = c[7];
        hz.ex_is_branch         = c[6];
        hz.ex_mem_mem_read      = c[5];
        hz.branch_mispredict    = c[4];
        hz.branch_redirect_id   = c[3];
        hz.inst_mem_wait        = c[2];
        hz.data_mem_wait        = c[1];
        hz.if_id_next_valid     = c[0];
        hz.id_ex_rd             = rd_ex;
        hz.ex_mem_rd            = rd_mem;
        hz.if_id_inst           = inst;
        hz.next_pc              = npc;
        e.outs = eo;
        e.pc   = ep;
        e.id   = n_vec;
        exp_q.push_back(e);
        n_vec++;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [14:0] act;
        forever begin
            @(negedge clk_10M);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {hz.hazard_stall, hz.mem_stall, hz.flush_mask, hz.if_id_load, hz.if_id_bubble,
                       hz.id_ex_load, hz.id_ex_bubble, hz.ex_mem_load, hz.ex_mem_bubble,
                       hz.mem_wb_load, hz.mem_wb_bubble};
                checks++;
                if (act !== e.outs) begin
                    failures++;
                    $display("FAIL v%0d ctrl got %b want %b", e.id, act, e.outs);
                end
                checks++;
                if (hz.pc !== e.pc) begin
                    failures++;
                    $display("FAIL v%0d pc got %h want %h", e.id, hz.pc, e.pc);
                end
            end
        end
    end

    initial begin : driver
        vec(1, NONE,          0, 0, 32'h0,      32'h8000_0000, O_IDLE,  32'h8000_0000);
        vec(0, NV,            0, 0, 32'h0,      32'h8000_0004, O_RUN,   32'h8000_0000);
        vec(0, MR|NV,         5, 0, ADD_1_5_6,  32'h8000_0008, O_STALL, 32'h8000_0004);
        vec(0, MR|NV,         0, 0, ADD_1_5_6,  32'h8000_0008, O_RUN,   32'h8000_0004);
        vec(0, MR|NV,         5, 0, LUI_RS1F5,  32'h8000_000C, O_RUN,   32'h8000_0008);
        vec(0, MR|NV,         5, 0, SW_5_2,     32'h8000_0010, O_STALL, 32'h8000_000C);
        vec(0, MR|NV,         6, 0, ADDI_RS2F6, 32'h8000_0010, O_RUN,   32'h8000_000C);
        vec(0, RW|NV,         3, 0, BEQ_3_4,    32'h8000_0014, O_STALL, 32'h8000_0010);
        vec(0, EMR|NV,        0, 3, BEQ_3_4,    32'h8000_0014, O_STALL, 32'h8000_0010);
        vec(0, NV,            0, 0, BEQ_3_4,    32'h8000_0014, O_RUN,   32'h8000_0010);
        vec(0, RD,            0, 0, 32'h0,      32'h8000_0040, O_REDIR, 32'h8000_0014);
        vec(0, RD|RW|NV,      4, 0, BEQ_3_4,    32'h8000_0080, O_STALL, 32'h8000_0040);
        vec(0, MR|MP|XB|NV,   5, 0, ADD_1_5_6,  32'h8000_0100, O_MISP,  32'h8000_0040);
        vec(0, MR|MP|NV,      5, 0, ADD_1_5_6,  32'h8000_0180, O_STALL, 32'h8000_0100);
        for (int i = 0; i < 3; i++)
            vec(0, MP|XB|DW|NV, 0, 0, 32'h0,    32'h8000_0200, O_WMISP, 32'h8000_0100);
        vec(0, MP|XB|NV,      0, 0, 32'h0,      32'h8000_0200, O_MISP,  32'h8000_0100);
        vec(0, IW|NV,         0, 0, 32'h0,      32'h8000_0300, O_WAIT,  32'h8000_0200);
        vec(1, NV,            0, 0, 32'h0,      32'h8000_0300, O_RUN,   32'h8000_0000);
        vec(0, NONE,          0, 0, 32'h0,      32'h8000_0300, O_IDLE,  32'h8000_0000);
        vec(0, NONE,          0, 0, 32'h0,      32'h8000_0300, O_IDLE,  32'h8000_0000);
        vec(0, NV,            0, 0, 32'h0,      32'h8000_0004, O_RUN,   32'h8000_0000);
        vec(0, NONE,          0, 0, 32'h0,      32'h8000_0004, O_IDLE,  32'h8000_0004);
        vec(0, RW|NV,         3, 0, JALR_1_3,   32'h8000_0008, O_STALL, 32'h8000_0004);
        vec(0, RW|NV,         0, 0, JALR_1_3,   32'h8000_0008, O_RUN,   32'h8000_0004);
        vec(0, RW|NV,         5, 0, ADD_1_5_6,  32'h8000_000C, O_RUN,   32'h8000_0008);
        vec(0, NONE,          0, 0, 32'h0,      32'h8000_000C, O_IDLE,  32'h8000_000C);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_10M);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
